// File: rtl/cga_intr_cntlr_reqgen.sv
// rtl/cga_intr_cntlr_reqgen.sv - CGA interrupt request generator: PID/PIE registers, level command FSM, request vector.
// Optional ACK auto-clear of PID bits is enabled by defining CGA_INTR_REQGEN_ACK_AUTOCLR_EN.
module cga_intr_cntlr_reqgen (
    input  logic        sysclk,
    input  logic        sys_rst,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP_1_0,
    input  logic [3:0]  CMD_LVL_3_0,
    input  logic        LDPIE,
    input  logic [15:0] PIE_15_0,
    input  logic        ACK,
    input  logic [3:0]  ACK_LVL_3_0,
    output logic [15:0] MIREQ_15_0_N,
    output logic [15:0] PID_15_0,
    output logic [15:0] PIE_OUT_15_0,
    output logic        INTPEND
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    localparam logic [1:0] OP_SET_PID = 2'b00;
    localparam logic [1:0] OP_CLR_PID = 2'b01;
    localparam logic [1:0] OP_SET_PIE = 2'b10;
    localparam logic [1:0] OP_CLR_PIE = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  lvl_q, lvl_d;
    logic [15:0] pid_q, pid_d;
    logic [15:0] pie_q, pie_d;
    logic [15:0] mireq_n_q;
    logic        intpend_q;
    logic [15:0] cmd_mask;
    logic        apply;

`ifdef CGA_INTR_REQGEN_ACK_AUTOCLR_EN
    logic [15:0] ack_mask;
    assign ack_mask = ACK ? (16'h0001 << ACK_LVL_3_0) : 16'h0000;
`else
    logic        unused_ack;
    assign unused_ack = ACK ^ (^ACK_LVL_3_0);
`endif

    assign cmd_mask = 16'h0001 << lvl_q;
    assign apply    = (state_q == ST_APPLY);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        lvl_d   = lvl_q;
        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    op_d    = CMD_OP_1_0;
                    lvl_d   = CMD_LVL_3_0;
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ACK clear is applied first so a same-cycle set command on that bit wins.
    always_comb begin
        pid_d = pid_q;
`ifdef CGA_INTR_REQGEN_ACK_AUTOCLR_EN
        pid_d = pid_d & ~ack_mask;
`endif
        if (apply && op_q == OP_SET_PID) pid_d = pid_d | cmd_mask;
        if (apply && op_q == OP_CLR_PID) pid_d = pid_d & ~cmd_mask;
    end

    // Bulk load first, then the command modifies its single bit on top.
    always_comb begin
        pie_d = LDPIE ? PIE_15_0 : pie_q;
        if (apply && op_q == OP_SET_PIE) pie_d = pie_d | cmd_mask;
        if (apply && op_q == OP_CLR_PIE) pie_d = pie_d & ~cmd_mask;
    end

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            op_q      <= 2'b00;
            lvl_q     <= 4'h0;
            pid_q     <= 16'h0000;
            pie_q     <= 16'h0000;
            mireq_n_q <= 16'hFFFF;
            intpend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            lvl_q     <= lvl_d;
            pid_q     <= pid_d;
            pie_q     <= pie_d;
            mireq_n_q <= ~(pid_q & pie_q);
            intpend_q <= |(pid_q & pie_q);
        end
    end

    assign CMD_READY    = (state_q == ST_IDLE);
    assign MIREQ_15_0_N = mireq_n_q;
    assign PID_15_0     = pid_q;
    assign PIE_OUT_15_0 = pie_q;
    assign INTPEND      = intpend_q;

endmodule

// File: doc/cga_intr_cntlr_reqgen.md
# cga_intr_cntlr_reqgen

Interrupt request generator for the CGA interrupt controller. Maintains the 16-level pending-interrupt register (PID) and enable register (PIE). Decodes 4-bit level commands into set/clear operations on individual PID bits. Drives the active-low, registered request vector `MIREQ_15_0_N` that feeds the priority vector generator; acknowledges from the vector side retire the served level.

## Interface
Parameters: none.

- `sysclk` in 1: system clock; all state changes on rising edge.
- `sys_rst` in 1: synchronous, active-high reset.
- `CMD_VALID` in 1: command request; held until accepted.
- `CMD_READY` out 1: command port can accept; transfer when `CMD_VALID & CMD_READY`.
- `CMD_OP_1_0` in 2: 00 = set PID bit, 01 = clear PID bit, 10 = set PIE bit, 11 = clear PIE bit.
- `CMD_LVL_3_0` in 4: level number 0..15 addressed by the command.
- `LDPIE` in 1: one-cycle strobe, bulk load of PIE from `PIE_15_0`.
- `PIE_15_0` in 16: PIE load data.
- `ACK` in 1: one-cycle strobe, level `ACK_LVL_3_0` has been served.
- `ACK_LVL_3_0` in 4: acknowledged level.
- `MIREQ_15_0_N` out 16: registered `~(PID & PIE)`; bit n low = level n requesting.
- `PID_15_0` out 16: current PID register.
- `PIE_OUT_15_0` out 16: current PIE register.
- `INTPEND` out 1: registered OR of `PID & PIE`.

## Operation
- Command FSM states: IDLE, APPLY.
  - IDLE: `CMD_READY`=1. On transfer, latch op and level, go to APPLY.
  - APPLY: `CMD_READY`=0. Decode the level to a one-hot mask, modify PID or PIE, return to IDLE.
  - Maximum throughput is one command per 2 cycles.
- Level decode: mask = 1 << `CMD_LVL_3_0`. Exactly one bit is affected per command. Other bits are unchanged.
- `LDPIE` replaces all of PIE. It is independent of the FSM.
- ACK clears PID bit `ACK_LVL_3_0` when the configuration enables auto-clear.
- Same-cycle priority, highest first:
  1. `sys_rst`
  2. APPLY PIE command vs `LDPIE`: `LDPIE` loads, then the APPLY bit modification is applied on top (command wins for its bit).
  3. APPLY PID set vs ACK clear of the same bit: set wins.
  4. APPLY PID clear vs ACK of the same bit: bit cleared.
  5. Operations on different bits are applied independently in the same cycle.
- `MIREQ_15_0_N` and `INTPEND` are computed from the PID/PIE values after update, registered once.

## Timing
- Reset values:
  - PID = 0000h, PIE = 0000h.
  - `MIREQ_15_0_N` = FFFFh, `INTPEND` = 0.
  - `CMD_READY` = 1, FSM = IDLE.
- Reset during APPLY drops the latched command. That command is never applied.
- Command latency:
  - transfer at edge T;
  - PID/PIE updated at edge T+1;
  - `MIREQ_15_0_N`/`INTPEND` reflect it at edge T+2.
- `CMD_READY` goes low in the cycle after transfer and returns high one cycle later.
- `LDPIE`/ACK at edge T: register updated at T, `MIREQ_15_0_N` at T+1.
- Commands that are set-to-set or clear-to-clear are idempotent. There are no error indications.
- `CMD_VALID` deasserted before transfer is legal. Nothing is latched.

## Configuration
- `CGA_INTR_REQGEN_ACK_AUTOCLR_EN` defined:
  - ACK clears the acknowledged PID bit per the priority rules.
- Not defined:
  - `ACK` and `ACK_LVL_3_0` are ignored.
  - PID bits are cleared only by the clear-PID command or reset.

## Test plan
- Reset, then `LDPIE` FFFFh, then command set-PID level 10 -> PID 0400h, `MIREQ_15_0_N` FBFFh and `INTPEND`=1 two edges after transfer.
- PIE 0000h, set-PID levels 3 and 15 -> PID 8008h, `MIREQ_15_0_N` stays FFFFh, `INTPEND`=0. Then set-PIE level 15 -> `MIREQ_15_0_N` 7FFFh.
- `CMD_VALID` held high with 4 back-to-back commands -> `CMD_READY` pattern 1,0,1,0…, each command applied exactly once, 8 cycles total.
- With `CGA_INTR_REQGEN_ACK_AUTOCLR_EN`, PID 0400h: `ACK` level 10 -> PID 0000h next edge, `MIREQ_15_0_N` FFFFh one edge later. Without the macro -> PID stays 0400h.
- Same-cycle APPLY set-PID level 5 and ACK level 5 (macro on) -> PID bit 5 = 1. Same cycle with ACK level 6 while bit 6 is set -> bit 6 cleared, bit 5 set.
- `sys_rst` asserted in the APPLY cycle of set-PID level 2 -> PID 0000h, `MIREQ_15_0_N` FFFFh, `CMD_READY`=1 after reset, command lost.
